// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM
// as two half-word transfers (low half, then high half), freezing the pipeline via ready.
module sram_mem_controller #(
    parameter int unsigned BIT_NUMBER      = 32,
    parameter int unsigned SRAM_ADDR_WIDTH = 18,
    parameter int unsigned PHASE_CYCLES    = 2,
    parameter int unsigned MEM_BASE        = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [BIT_NUMBER-1:0]      address,
    input  logic [BIT_NUMBER-1:0]      write_data,
    output logic [BIT_NUMBER-1:0]      read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]                sram_dq_out,
    output logic                       sram_dq_oe,
    input  logic [15:0]                sram_dq_in,
    output logic                       sram_we_n
);

    localparam int unsigned CNT_W   = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned WADDR_W = SRAM_ADDR_WIDTH - 1;
    localparam int unsigned HALF_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic               req;
    logic               phase_last;
    logic [WADDR_W-1:0] waddr;

    assign req        = rd_en | wr_en;
    assign phase_last = (cnt == CNT_W'(PHASE_CYCLES - 1));
    // Below-base addresses simply wrap; the result is truncated to the SRAM word space.
    assign waddr      = WADDR_W'((address - BIT_NUMBER'(MEM_BASE)) >> 2);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)        state_nxt = LOW;
            LOW:     if (phase_last) state_nxt = HIGH;
            HIGH:    if (phase_last) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Phase counter, latched operation and read capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_wr <= wr_en;
                    end
                end
                LOW, HIGH: cnt <= phase_last ? '0 : cnt + CNT_W'(1);
                default:   cnt <= '0;
            endcase
            if (!op_wr && phase_last && (state == LOW)) begin
                read_data[HALF_W-1:0] <= sram_dq_in;
            end
            if (!op_wr && phase_last && (state == HIGH)) begin
                read_data[2*HALF_W-1:HALF_W] <= sram_dq_in;
            end
        end
    end

    // Output decode; the last cycle of each write phase releases we_n while data is still held
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: ready = ~req;
            LOW: begin
                sram_addr = {waddr, 1'b0};
                if (op_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = phase_last;
                    sram_dq_out = write_data[HALF_W-1:0];
                end
            end
            HIGH: begin
                sram_addr = {waddr, 1'b1};
                if (op_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = phase_last;
                    sram_dq_out = write_data[2*HALF_W-1:HALF_W];
                end
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule
